// File: rtl/dmem_arbiter_if.sv
// Signal bundle joining the two requesting masters, the arbiter and the shared data-memory port.
// Grouped so the arbiter presents one port; the slave modport is the arbiter's view.
interface dmem_arbiter_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;

  logic          m0_req;
  logic          m0_lock;
  logic [BW-1:0] m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_lock;
  logic [BW-1:0] m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] dread_addr;
  logic [DW-1:0] dread_data;
  logic [AW-1:0] dwrite_addr;
  logic [DW-1:0] dwrite_data;
  logic [BW-1:0] dwrite_en;

  modport slave (
    input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
    input  dread_data,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output dread_addr, dwrite_addr, dwrite_data, dwrite_en
  );

  modport master (
    output m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
    output dread_data,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  dread_addr, dwrite_addr, dwrite_data, dwrite_en
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port: zero-cycle grant, bounded locking, 1-cycle reads.
// Define DMEM_ARB_FIXED_PRIO_EN to make m0 win every unlocked tie instead of round-robin.
module dmem_arbiter #(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_M0   = 2'd1,
    SEL_M1   = 2'd2
  } sel_e;

  sel_e          owner_q, owner_d;
  sel_e          win;
  logic          last_q, last_d;      // 1 when m1 was the most recent winner
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rv_vld_q, rv_vld_d;
  logic          rv_m1_q, rv_m1_d;

  logic          cnt_at_max;
  logic          win_lock;
  logic [BW-1:0] win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  assign cnt_at_max = (lock_cnt_q == CW'(MAX_LOCK));

  // Winner selection; reset forces no winner so every output drops asynchronously.
  always_comb begin
    win = SEL_NONE;
    if (!reset) begin
      if (owner_q == SEL_M0 && bus.m0_req) begin
        win = (cnt_at_max && bus.m1_req) ? SEL_M1 : SEL_M0;
      end else if (owner_q == SEL_M1 && bus.m1_req) begin
        win = (cnt_at_max && bus.m0_req) ? SEL_M0 : SEL_M1;
      end else if (bus.m0_req && bus.m1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        win = SEL_M0;
`else
        win = last_q ? SEL_M0 : SEL_M1;
`endif
      end else if (bus.m0_req) begin
        win = SEL_M0;
      end else if (bus.m1_req) begin
        win = SEL_M1;
      end
    end
  end

  // Winner's request fields routed toward the memory port.
  always_comb begin
    win_lock  = 1'b0;
    win_we    = '0;
    win_addr  = '0;
    win_wdata = '0;
    case (win)
      SEL_M0: begin
        win_lock  = bus.m0_lock;
        win_we    = bus.m0_we;
        win_addr  = bus.m0_addr;
        win_wdata = bus.m0_wdata;
      end
      SEL_M1: begin
        win_lock  = bus.m1_lock;
        win_we    = bus.m1_we;
        win_addr  = bus.m1_addr;
        win_wdata = bus.m1_wdata;
      end
      default: ;
    endcase
  end

  // Next-state: lock ownership/count, last winner, pending read return.
  always_comb begin
    owner_d    = SEL_NONE;
    lock_cnt_d = '0;
    last_d     = last_q;
    rv_vld_d   = 1'b0;
    rv_m1_d    = rv_m1_q;
    if (win != SEL_NONE) begin
      last_d   = (win == SEL_M1);
      rv_vld_d = (win_we == '0);
      rv_m1_d  = (win == SEL_M1);
      if (win_lock) begin
        owner_d = win;
        // A forced takeover never matches owner_q, so the new owner restarts at 1.
        if (owner_q == win) begin
          lock_cnt_d = cnt_at_max ? lock_cnt_q : lock_cnt_q + CW'(1);
        end else begin
          lock_cnt_d = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= SEL_NONE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      rv_vld_q   <= 1'b0;
      rv_m1_q    <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rv_vld_q   <= rv_vld_d;
      rv_m1_q    <= rv_m1_d;
    end
  end

  assign bus.m0_gnt      = (win == SEL_M0);
  assign bus.m1_gnt      = (win == SEL_M1);
  assign bus.m0_rvalid   = rv_vld_q & ~rv_m1_q;
  assign bus.m1_rvalid   = rv_vld_q &  rv_m1_q;
  assign bus.m0_rdata    = bus.dread_data;
  assign bus.m1_rdata    = bus.dread_data;

  assign bus.dread_addr  = win_addr;
  assign bus.dwrite_en   = win_we;
  assign bus.dwrite_addr = (win_we != '0) ? win_addr  : '0;
  assign bus.dwrite_data = (win_we != '0) ? win_wdata : '0;

`ifndef SYNTHESIS
  a_one_gnt: assert property (@(posedge clk) disable iff (reset)
    !(bus.m0_gnt && bus.m1_gnt));
  a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
    lock_cnt_q <= CW'(MAX_LOCK));
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with MAX_LOCK=4 and a byte-lane memory model on the shared port.
module tb_dmem_arbiter;
  localparam int unsigned MAX_LOCK_TB = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MAX_LOCK(MAX_LOCK_TB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: reset fills word k with 16'hA500|k; reads return one cycle later.
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 256; k++) mem[k] <= 16'hA500 | 16'(k);
    end else begin
      if (bus.dwrite_en[0]) mem[bus.dwrite_addr[8:1]][7:0]  <= bus.dwrite_data[7:0];
      if (bus.dwrite_en[1]) mem[bus.dwrite_addr[8:1]][15:8] <= bus.dwrite_data[15:8];
    end
    bus.dread_data <= mem[bus.dread_addr[8:1]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input int m, input logic req, input logic lock, input logic [1:0] we,
                     input logic [15:0] addr, input logic [15:0] wdata);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_lock = lock; bus.m0_we = we;
      bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = req; bus.m1_lock = lock; bus.m1_we = we;
      bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000);
    drv(1, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000);
    repeat (3) step();

    // Held in reset with both requesting: everything quiet.
    check_eq("rst_m0_gnt",    32'(bus.m0_gnt),    32'd0);
    check_eq("rst_m1_gnt",    32'(bus.m1_gnt),    32'd0);
    check_eq("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
    check_eq("rst_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    check_eq("rst_dread_addr",32'(bus.dread_addr),32'd0);
    check_eq("rst_dwrite_en", 32'(bus.dwrite_en), 32'd0);

    reset = 1'b0;
    #1;
    check_eq("first_m0_gnt",  32'(bus.m0_gnt),    32'd1);
    check_eq("first_m1_gnt",  32'(bus.m1_gnt),    32'd0);
    check_eq("first_raddr",   32'(bus.dread_addr),32'h0010);
    step();
    check_eq("second_m1_gnt", 32'(bus.m1_gnt),    32'd1);
    check_eq("pre_rst_rvalid",32'(bus.m0_rvalid), 32'd1);

    // Mid-cycle reset drops grants and the pending rvalid at once.
    reset = 1'b1;
    #1;
    check_eq("async_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
    check_eq("async_m0_gnt",    32'(bus.m0_gnt),    32'd0);
    check_eq("async_m1_gnt",    32'(bus.m1_gnt),    32'd0);
    check_eq("async_raddr",     32'(bus.dread_addr),32'd0);
    reset = 1'b0;
    #1;

    // Round-robin on continuous reads: m0,m1,m0,m1,m0,m1; rvalid one cycle behind.
    for (int i = 0; i < 6; i++) begin
      check_eq("rr_m0_gnt", 32'(bus.m0_gnt), 32'((i % 2) == 0));
      check_eq("rr_m1_gnt", 32'(bus.m1_gnt), 32'((i % 2) == 1));
      if (i > 0) begin
        check_eq("rr_m0_rvalid", 32'(bus.m0_rvalid), 32'(((i - 1) % 2) == 0));
        check_eq("rr_m1_rvalid", 32'(bus.m1_rvalid), 32'(((i - 1) % 2) == 1));
        if (((i - 1) % 2) == 0) check_eq("rr_m0_rdata", 32'(bus.m0_rdata), 32'hA508);
        else                    check_eq("rr_m1_rdata", 32'(bus.m1_rdata), 32'hA510);
      end
      step();
    end
    check_eq("rr_tail_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
    check_eq("rr_tail_m1_rdata",  32'(bus.m1_rdata),  32'hA510);

    // m1 full write, read back, then low-byte write and read back.
    drv(0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    drv(1, 1'b1, 1'b0, 2'b11, 16'h0040, 16'hBEEF);
    #1;
    check_eq("wr_m1_gnt",   32'(bus.m1_gnt),      32'd1);
    check_eq("wr_en",       32'(bus.dwrite_en),   32'h3);
    check_eq("wr_addr",     32'(bus.dwrite_addr), 32'h0040);
    check_eq("wr_data",     32'(bus.dwrite_data), 32'hBEEF);
    check_eq("wr_raddr",    32'(bus.dread_addr),  32'h0040);
    step();
    check_eq("wr_no_rvalid",32'(bus.m1_rvalid),   32'd0);
    drv(1, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000);
    #1;
    check_eq("rd_m1_gnt",   32'(bus.m1_gnt),      32'd1);
    check_eq("rd_wr_en",    32'(bus.dwrite_en),   32'h0);
    step();
    check_eq("rb_m1_rvalid",32'(bus.m1_rvalid),   32'd1);
    check_eq("rb_m1_rdata", 32'(bus.m1_rdata),    32'hBEEF);
    check_eq("rb_m0_rvalid",32'(bus.m0_rvalid),   32'd0);
    drv(1, 1'b1, 1'b0, 2'b01, 16'h0040, 16'h1234);
    #1;
    check_eq("bw_en",       32'(bus.dwrite_en),   32'h1);
    step();
    drv(1, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000);
    step();
    check_eq("bw_rdata",    32'(bus.m1_rdata),    32'hBE34);

    // Lone m0 read so that m1 wins the next tie.
    drv(1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    drv(0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000);
    #1;
    check_eq("solo_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    step();

    // m1 locks while m0 keeps asking: m1 x4, m0, m1 x4, m0.
    drv(1, 1'b1, 1'b1, 2'b00, 16'h0020, 16'h0000);
    #1;
    for (int i = 0; i < 10; i++) begin
      check_eq("lk_m0_gnt", 32'(bus.m0_gnt), 32'(i == 4 || i == 9));
      check_eq("lk_m1_gnt", 32'(bus.m1_gnt), 32'(i != 4 && i != 9));
      step();
    end

    // m0 locked burst, reset in its second cycle, then the count restarts from 1.
    drv(1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    drv(0, 1'b1, 1'b1, 2'b00, 16'h0010, 16'h0000);
    #1;
    check_eq("lb1_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    step();
    drv(1, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000);
    #1;
    check_eq("lb2_m0_gnt",    32'(bus.m0_gnt),    32'd1);
    check_eq("lb2_m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("lb_rst_rvalid", 32'(bus.m0_rvalid), 32'd0);
    check_eq("lb_rst_gnt",    32'(bus.m0_gnt),    32'd0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("lr_m0_gnt", 32'(bus.m0_gnt), 32'(i < 4));
      check_eq("lr_m1_gnt", 32'(bus.m1_gnt), 32'(i == 4));
      step();
    end

    // Unlocked tie for 5 cycles; previous winner was m1.
    drv(0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000);
    drv(1, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000);
    #1;
    for (int i = 0; i < 5; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      check_eq("tie_m0_gnt", 32'(bus.m0_gnt), 32'd1);
      check_eq("tie_m1_gnt", 32'(bus.m1_gnt), 32'd0);
`else
      check_eq("tie_m0_gnt", 32'(bus.m0_gnt), 32'((i % 2) == 0));
      check_eq("tie_m1_gnt", 32'(bus.m1_gnt), 32'((i % 2) == 1));
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the f8 system's single data-memory port (`dread_*` / `dwrite_*`) between master 0 (CPU data side) and master 1 (debug loader / DMA).
- Resolves contention per cycle: round-robin by default, fixed priority when compiled so.
- Supports bounded bus locking for multi-word transfers.
- Returns read data with the memory's fixed one-cycle latency.

## Interface
Parameters:
- `MAX_LOCK`, 8: maximum consecutive locked grants to one master while the other is requesting (1..255).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `m0_req`, `m1_req`  in  1  access request, one access per granted cycle.
- `m0_lock`, `m1_lock`  in  1  keep the grant on the next cycle.
- `m0_we`, `m1_we`  in  2  byte write enables; `2'b00` means read.
- `m0_addr`, `m1_addr`  in  16  byte address.
- `m0_wdata`, `m1_wdata`  in  16  write data.
- `m0_gnt`, `m1_gnt`  out  1  access accepted this cycle; combinational.
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid; registered.
- `m0_rdata`, `m1_rdata`  out  16  read data; mirrors `dread_data`.
- `dread_addr`  out  16  memory read address.
- `dread_data`  in  16  memory read data, valid one cycle after `dread_addr`.
- `dwrite_addr`  out  16  memory write address.
- `dwrite_data`  out  16  memory write data.
- `dwrite_en`  out  2  memory byte write enables.

## Operation
- **State:**
  - `owner`: none / m0 / m1; the locked owner, if any.
  - `last`: last winner, resets to m1 so that m0 wins the first tie.
  - `lock_cnt`: 8-bit saturating counter.
  - `rv_sel`: pending read's master plus valid bit.
- **Winner selection, in order:**
  1. If `owner` is set and its `req` is high: the owner wins, unless `lock_cnt == MAX_LOCK` and the other master requests, in which case the other master wins.
  2. If only one master requests, it wins.
  3. If both request, the master that is not `last` wins.
  4. If neither requests, there is no winner.
- **Grant:** the winner's `gnt` is 1 in the same cycle; the loser's `gnt` is 0 and it must hold `req`, address and data stable until granted.
- **Memory drive, winner with a read (`we == 0`):**
  - `dread_addr` = winner's address.
  - `dwrite_en` = 0.
- **Memory drive, winner with a write:**
  - `dwrite_addr`, `dwrite_data`, `dwrite_en` = winner's address, data and enables.
  - `dread_addr` = winner's address.
- **Memory drive, no winner:** all memory outputs are 0.
- **Lock tracking:**
  - If the winner's `lock` is high: `owner` = winner. `lock_cnt` increments (saturating at `MAX_LOCK`) when the winner is unchanged from the previous cycle; otherwise it loads 1.
  - If the winner's `lock` is low: `owner` = none and `lock_cnt` = 0.
  - A forced release (the takeover in selection rule 1) clears `owner` and `lock_cnt` before the new winner's own lock is applied.
- **Read return:** a granted read sets `rv_sel`. The next cycle asserts that master's `rvalid`. `rdata` for both masters is `dread_data`, ungated.

## Timing
- Grant and memory-side outputs are combinational from `req` and the registered state: zero-cycle arbitration.
- Read latency: `rvalid` is asserted exactly 1 cycle after `gnt` for a read; back-to-back reads give back-to-back `rvalid`.
- Writes complete in the granted cycle; no response is returned.
- **Reset values:**
  - `gnt`, `rvalid` and all memory outputs are 0.
  - `owner` = none, `last` = m1, `lock_cnt` = 0.
- **Reset mid-operation:** a pending `rvalid` is dropped and the lock is released; the first cycle after deassertion behaves as if out of reset.
- **Lock held with no request:** if the owner's `req` is low, the lock is abandoned and normal selection applies.
- **Starvation bound:** a requesting master waits at most `MAX_LOCK` cycles.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN`:
  - **Defined:** selection rule 3 always picks m0; `last` is still updated but ignored. Locking and the `MAX_LOCK` forced release are unchanged, so m1 is guaranteed progress only when m0 idles or holds a lock of its own.
  - **Undefined:** round-robin as described above.

## Test plan
- **Reset values:** assert `reset` mid-cycle with both masters requesting → all outputs are 0 asynchronously; after release, both reading → m0 is granted first.
- **Round-robin:** both masters issue reads continuously for 6 cycles → grants alternate m0, m1, m0, m1, m0, m1; each `rvalid` follows its grant by 1 cycle.
- **Write then read back:** m1 writes `we=2'b11`, addr `0x0040`, data `0xBEEF` → `dwrite_en=11`, `dwrite_addr=0x0040`, `dwrite_data=0xBEEF` in that cycle; m1 then reads `0x0040` → `m1_rvalid` with `m1_rdata=0xBEEF` one cycle later.
- **Lock bound:** with `MAX_LOCK=4`, m1 requests with lock for 10 cycles while m0 requests continuously → m1 granted 4 cycles, m0 1 cycle, m1 4 cycles, m0 1 cycle.
- **Reset during lock:** reset during the 2nd cycle of an m0 locked read burst → `rvalid` and `lock_cnt` clear; the next contended cycle grants m0 (`last` = m1).
- **Fixed-priority build:** with `DMEM_ARB_FIXED_PRIO_EN` defined, both masters request without lock for 5 cycles → m0 granted all 5 cycles, `m1_gnt` stays 0.
